// File: rtl/fft_frame_engine.sv
// Iterative radix-2 DIT FFT: circular sample window, bit-reversed load, in-place butterflies, natural-order drain.
// Optional FFT_STAGE_SCALE_EN halves both butterfly outputs every stage (outputs become DFT/N).
module fft_frame_engine #(
   parameter int LOG2N  = 8,
   parameter int IN_W   = 16,
   parameter int DATA_W = 32,
   parameter int FRAC_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_sample,
   input  logic              fft_req,
   output logic              busy,
   output logic              overrun,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LOG2N-1:0]  out_index,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_imag,
   output logic              out_last
);

   localparam int N  = 1 << LOG2N;
   localparam int HN = N / 2;
   localparam int TW = FRAC_W + 2;
   localparam int PW = DATA_W + FRAC_W + 3;
   localparam logic [LOG2N-1:0] ONE = 1;
   localparam real PI = 3.14159265358979323846;

   typedef enum logic [1:0] {IDLE, LOAD, BFLY, DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [LOG2N-1:0]         cnt_q, cnt_d, wp_q;
   logic [3:0]               stage_q, stage_d;
   logic                     pending_q, pending_d, overrun_q;
   logic signed [IN_W-1:0]   win_q [N];
   logic signed [DATA_W-1:0] wre_q [N];
   logic signed [DATA_W-1:0] wim_q [N];

   function automatic logic signed [TW-1:0] tw_val(input int k, input logic use_sin);
      real ang, v;
      ang = 2.0 * PI * real'(k) / real'(N);
      v   = (use_sin ? $sin(ang) : $cos(ang)) * real'(1 << FRAC_W);
      return TW'(longint'(v));
   endfunction

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   logic signed [TW-1:0] tw_cos [HN];
   logic signed [TW-1:0] tw_sin [HN];
   for (genvar g = 0; g < HN; g++) begin : g_tw
      localparam logic signed [TW-1:0] C = tw_val(g, 1'b0);
      localparam logic signed [TW-1:0] S = tw_val(g, 1'b1);
      assign tw_cos[g] = C;
      assign tw_sin[g] = S;
   end

   // Window runs independently of the FSM; it only pauses while LOAD reads it.
   logic accept;
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q <= '0;
         for (int unsigned i = 0; i < N; i++) win_q[i] <= '0;
      end else if (accept) begin
         win_q[wp_q] <= in_sample;
         wp_q        <= wp_q + ONE;
      end
   end

   logic [LOG2N-1:0]         rd_idx, j_x, mask, bf_a, bf_b;
   logic [LOG2N-2:0]         tw_k;
   logic signed [DATA_W-1:0] ld_val, ar, ai, t_re, t_im, nar, nai, nbr, nbi;
   logic signed [PW-1:0]     br_x, bi_x, wr_x, wi_x, pr, pi;
   logic                     unused_bits;
`ifdef FFT_STAGE_SCALE_EN
   logic signed [DATA_W:0]   sar, sai, sbr, sbi;
`endif

   always_comb begin
      rd_idx = wp_q + cnt_q;
      ld_val = DATA_W'(win_q[rd_idx]);
      j_x    = {1'b0, cnt_q[LOG2N-2:0]};
      mask   = (ONE << stage_q) - ONE;
      bf_a   = ((j_x >> stage_q) << (stage_q + 4'd1)) | (j_x & mask);
      bf_b   = bf_a | (ONE << stage_q);
      tw_k   = (cnt_q[LOG2N-2:0] & mask[LOG2N-2:0]) << (4'(LOG2N-1) - stage_q);
      ar     = wre_q[bf_a];
      ai     = wim_q[bf_a];
      br_x   = PW'(wre_q[bf_b]);
      bi_x   = PW'(wim_q[bf_b]);
      wr_x   = PW'(tw_cos[tw_k]);
      wi_x   = -PW'(tw_sin[tw_k]);
      // Full-precision complex product, then floor-shift by taking the slice above FRAC_W.
      pr     = wr_x * br_x - wi_x * bi_x;
      pi     = wr_x * bi_x + wi_x * br_x;
      t_re   = pr[FRAC_W +: DATA_W];
      t_im   = pi[FRAC_W +: DATA_W];
`ifdef FFT_STAGE_SCALE_EN
      sar    = {ar[DATA_W-1], ar} + {t_re[DATA_W-1], t_re};
      sai    = {ai[DATA_W-1], ai} + {t_im[DATA_W-1], t_im};
      sbr    = {ar[DATA_W-1], ar} - {t_re[DATA_W-1], t_re};
      sbi    = {ai[DATA_W-1], ai} - {t_im[DATA_W-1], t_im};
      nar    = sar[DATA_W:1];
      nai    = sai[DATA_W:1];
      nbr    = sbr[DATA_W:1];
      nbi    = sbi[DATA_W:1];
      unused_bits = ^{pr[PW-1:FRAC_W+DATA_W], pr[FRAC_W-1:0], pi[PW-1:FRAC_W+DATA_W],
                      pi[FRAC_W-1:0], sar[0], sai[0], sbr[0], sbi[0]};
`else
      nar    = ar + t_re;
      nai    = ai + t_im;
      nbr    = ar - t_re;
      nbi    = ai - t_im;
      unused_bits = ^{pr[PW-1:FRAC_W+DATA_W], pr[FRAC_W-1:0], pi[PW-1:FRAC_W+DATA_W],
                      pi[FRAC_W-1:0]};
`endif
   end

   always_ff @(posedge clk) begin
      case (state_q)
         LOAD: begin
            wre_q[bitrev(cnt_q)] <= ld_val;
            wim_q[bitrev(cnt_q)] <= '0;
         end
         BFLY: begin
            wre_q[bf_a] <= nar;
            wim_q[bf_a] <= nai;
            wre_q[bf_b] <= nbr;
            wim_q[bf_b] <= nbi;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stage_d   = stage_q;
      pending_d = pending_q;
      if (fft_req && state_q != IDLE) pending_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (fft_req || pending_q) begin
               state_d   = LOAD;
               cnt_d     = '0;
               pending_d = 1'b0;
            end
         end
         LOAD: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == '1) begin
               state_d = BFLY;
               stage_d = '0;
               cnt_d   = '0;
            end
         end
         BFLY: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q[LOG2N-2:0] == '1) begin
               cnt_d = '0;
               if (stage_q == 4'(LOG2N-1)) state_d = DRAIN;
               else                        stage_d = stage_q + 4'd1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               cnt_d = cnt_q + ONE;
               if (cnt_q == '1) begin
                  cnt_d = '0;
                  if (pending_q) begin
                     state_d   = LOAD;
                     pending_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         stage_q   <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         pending_q <= pending_d;
         overrun_q <= fft_req && pending_q;
      end
   end

   always_comb begin
      in_ready  = state_q != LOAD;
      busy      = state_q != IDLE;
      overrun   = overrun_q;
      out_valid = state_q == DRAIN;
      out_index = out_valid ? cnt_q : '0;
      out_real  = out_valid ? wre_q[cnt_q] : '0;
      out_imag  = out_valid ? wim_q[cnt_q] : '0;
      out_last  = out_valid && cnt_q == '1;
   end

endmodule
